// File: rtl/simon64_96_decrypt_iter.sv
// Iterative SIMON64/96 decryption core: expands a loaded 96-bit key into 42 stored
// round keys, then decrypts one 64-bit block per 42 cycles, one round per cycle.
module simon64_96_decrypt_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [95:0] key,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] in_text,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] out_text,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   typedef enum logic [2:0] {NOKEY, EXPAND, IDLE, RUN, DONE} stateT;

   localparam logic [63:0] Z2 = 64'h7369f885192c0ef5;
   localparam logic [31:0] C  = 32'hfffffffc;

   // SIMON round function on one 32-bit word
   function automatic logic [31:0] roundF(input logic [31:0] v);
      return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
   endfunction

   // m = 3 key schedule step: c ^ z ^ k[i-3] ^ ROR3(k[i-1]) ^ ROR4(k[i-1])
   function automatic logic [31:0] expandWord(input logic [31:0] km1,
                                              input logic [31:0] km3,
                                              input logic        zBit);
      return C ^ {31'd0, zBit} ^ km3 ^ {km1[2:0], km1[31:3]} ^ {km1[3:0], km1[31:4]};
   endfunction

   stateT       stateR, stateS;
   logic [5:0]  cntR, cntS;
   logic [5:0]  rR, rS;
   logic [31:0] xR, xS, yR, yS;
   logic [63:0] outTextR, outTextS;
   logic        outValidR, outValidS;
   logic        busyR, keyReadyR, idleR;
   logic        keyLoadS, expWrS;
   logic [31:0] expWordS, roundYS;
   logic [31:0] roundKeyR [0:41];

   assign expWordS  = expandWord(roundKeyR[cntR - 6'd1], roundKeyR[cntR - 6'd3], Z2[cntR - 6'd3]);
   assign roundYS   = xR ^ roundF(yR) ^ roundKeyR[rR];

   assign key_ready = keyReadyR;
   assign in_ready  = idleR & ~key_valid;
   assign out_text  = outTextR;
   assign out_valid = outValidR;
   assign busy      = busyR;

   // Next-state, counter and datapath decode
   always_comb begin
      stateS    = stateR;
      cntS      = cntR;
      rS        = rR;
      xS        = xR;
      yS        = yR;
      outTextS  = outTextR;
      outValidS = outValidR;
      keyLoadS  = 1'b0;
      expWrS    = 1'b0;
      case (stateR)
         NOKEY: begin
            if (key_valid) begin
               keyLoadS = 1'b1;
               cntS     = 6'd3;
               stateS   = EXPAND;
            end else begin
               stateS   = NOKEY;
            end
         end
         EXPAND: begin
            expWrS = 1'b1;
            cntS   = cntR + 6'd1;
            if (cntR == 6'd41) begin
               stateS = IDLE;
            end else begin
               stateS = EXPAND;
            end
         end
         IDLE: begin
            if (key_valid) begin
               keyLoadS = 1'b1;
               cntS     = 6'd3;
               stateS   = EXPAND;
            end else if (in_valid) begin
               xS     = in_text[63:32];
               yS     = in_text[31:0];
               rS     = 6'd41;
               stateS = RUN;
            end else begin
               stateS = IDLE;
            end
         end
         RUN: begin
            xS = yR;
            yS = roundYS;
            if (rR == 6'd0) begin
               outTextS  = {yR, roundYS};
               outValidS = 1'b1;
               stateS    = DONE;
            end else begin
               rS = rR - 6'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               outValidS = 1'b0;
               stateS    = IDLE;
            end else begin
               stateS    = DONE;
            end
         end
         default: begin
            stateS = NOKEY;
         end
      endcase
   end

   // Control and data registers, with status outputs registered from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateR    <= NOKEY;
         cntR      <= 6'd0;
         rR        <= 6'd0;
         xR        <= 32'd0;
         yR        <= 32'd0;
         outTextR  <= 64'd0;
         outValidR <= 1'b0;
         busyR     <= 1'b0;
         keyReadyR <= 1'b1;
         idleR     <= 1'b0;
      end else begin
         stateR    <= stateS;
         cntR      <= cntS;
         rR        <= rS;
         xR        <= xS;
         yR        <= yS;
         outTextR  <= outTextS;
         outValidR <= outValidS;
         busyR     <= (stateS == EXPAND) || (stateS == RUN);
         keyReadyR <= (stateS == NOKEY) || (stateS == IDLE);
         idleR     <= (stateS == IDLE);
      end
   end

   // Round-key storage: deliberately unreset, the FSM tracks validity
   always_ff @(posedge clk) begin
      if (rst_n && keyLoadS) begin
         roundKeyR[0] <= key[31:0];
         roundKeyR[1] <= key[63:32];
         roundKeyR[2] <= key[95:64];
      end else if (rst_n && expWrS) begin
         roundKeyR[cntR] <= expWordS;
      end
   end

endmodule
